// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/write-back control FSM.
// Fetches 8-bit instructions over a req/ack port, decodes the opcode into an
// ALU select and issues single-cycle register/memory write-enable pulses.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for run; no fetch activity
// FETCH  | imem_req high at PC; on ack latch instruction, PC += 1
// DECODE | opcode/operand stable; alu_ctrl reflects opcode
// EXEC   | resolve JMP/NOP/HALT/illegal or continue to write-back
// WB     | one-cycle reg_we (LOAD/ALU) or mem_we (STORE) pulse
// HALT   | absorbing; only rst leaves
module cpu_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_data,
  output logic [3:0]          opcode,
  output logic [3:0]          operand,
  output logic [2:0]          alu_ctrl,
  output logic                reg_we,
  output logic                mem_we,
  output logic                halted,
  output logic                illegal
);

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // JMP keeps the page bits of the already-incremented PC and replaces the low nibble.
  localparam logic [PC_WIDTH-1:0] PAGE_MASK = ~PC_WIDTH'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          ir_q;
  logic                illegal_q;
  logic [3:0]          op;
  logic                op_writes_back;
  logic                op_defined;
  logic [PC_WIDTH-1:0] jmp_target;

  assign op             = ir_q[7:4];
  assign op_writes_back = (op <= OP_XOR);
  assign op_defined     = op_writes_back || (op == OP_JMP) || (op == OP_NOP) || (op == OP_HALT);
  assign jmp_target     = (pc_q & PAGE_MASK) | PC_WIDTH'(ir_q[3:0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // PC, instruction register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && imem_ack) begin
        pc_q <= pc_q + PC_WIDTH'(1);
        ir_q <= imem_data;
      end
      if (state_q == S_EXEC) begin
        if (op == OP_JMP) pc_q      <= jmp_target;
        if (!op_defined)  illegal_q <= 1'b1;
      end
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op_writes_back)     state_d = S_WB;
        else if (op == OP_HALT) state_d = S_HALT;
        else                    state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched instruction
  always_comb begin
    imem_req  = (state_q == S_FETCH);
    imem_addr = pc_q;
    opcode    = ir_q[7:4];
    operand   = ir_q[3:0];
    reg_we    = (state_q == S_WB) && (op != OP_STORE);
    mem_we    = (state_q == S_WB) && (op == OP_STORE);
    halted    = (state_q == S_HALT);
    illegal   = illegal_q;
    case (op)
      OP_ADD:  alu_ctrl = 3'b000;
      OP_SUB:  alu_ctrl = 3'b001;
      OP_AND:  alu_ctrl = 3'b010;
      OP_OR:   alu_ctrl = 3'b011;
      OP_XOR:  alu_ctrl = 3'b100;
      default: alu_ctrl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level reference model predicts every
// cycle's outputs; directed programs pin the model with literal expectations,
// then randomized programs, ack delays, run and reset exercise the rest.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, run = 1'b0, imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;

  logic       req8, rwe8, mwe8, halt8, ill8;
  logic [7:0] addr8;
  logic [3:0] op8, opr8;
  logic [2:0] alu8;
  logic       req4, rwe4, mwe4, halt4, ill4;
  logic [3:0] addr4;
  logic [3:0] op4, opr4;
  logic [2:0] alu4;

  cpu_sequencer #(.PC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .run(run), .imem_req(req8), .imem_addr(addr8),
    .imem_ack(imem_ack), .imem_data(imem_data), .opcode(op8), .operand(opr8),
    .alu_ctrl(alu8), .reg_we(rwe8), .mem_we(mwe8), .halted(halt8), .illegal(ill8));

  cpu_sequencer #(.PC_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .run(run), .imem_req(req4), .imem_addr(addr4),
    .imem_ack(imem_ack), .imem_data(imem_data), .opcode(op4), .operand(opr4),
    .alu_ctrl(alu4), .reg_we(rwe4), .mem_we(mwe4), .halted(halt4), .illegal(ill4));

  bit         sel = 1'b0;
  logic       cur_req, cur_rwe, cur_mwe, cur_halt, cur_ill;
  logic [7:0] cur_addr;
  logic [3:0] cur_op, cur_opr;
  logic [2:0] cur_alu;
  assign cur_req  = sel ? req4  : req8;
  assign cur_rwe  = sel ? rwe4  : rwe8;
  assign cur_mwe  = sel ? mwe4  : mwe8;
  assign cur_halt = sel ? halt4 : halt8;
  assign cur_ill  = sel ? ill4  : ill8;
  assign cur_addr = sel ? {4'b0, addr4} : addr8;
  assign cur_op   = sel ? op4   : op8;
  assign cur_opr  = sel ? opr4  : opr8;
  assign cur_alu  = sel ? alu4  : alu8;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  localparam int P_IDLE = 0, P_FETCH = 1, P_BUSY = 2, P_HALT = 3;
  int m_phase = P_IDLE;
  int m_pc = 0, m_op = 0, m_opr = 0;
  bit m_ill = 0;
  int wb_q[$];               // per remaining busy cycle: 0 none, 1 reg_we, 2 mem_we
  int pend_pc = 0;
  bit pend_ill = 0, pend_halt = 0;
  bit e_rwe, e_mwe, e_busy;

  function automatic int alu_of(input int op);
    case (op)
      2: return 0;
      3: return 1;
      4: return 2;
      5: return 3;
      6: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit a_rst, input bit a_run, input bit a_ack, input int a_data);
    int w, v;
    w = sel ? 4 : 8;
    e_rwe = 0; e_mwe = 0; e_busy = 0;
    if (a_rst) begin
      m_pc = 0; m_op = 0; m_opr = 0; m_ill = 0;
      m_phase = P_IDLE; wb_q.delete();
      e_busy = 1;
    end else begin
      if (m_phase == P_IDLE && a_run) m_phase = P_FETCH;
      else if (m_phase == P_FETCH && a_ack) begin
        m_pc  = (m_pc + 1) % (1 << w);
        m_op  = (a_data >> 4) & 15;
        m_opr = a_data & 15;
        pend_pc = m_pc; pend_ill = 0; pend_halt = 0;
        wb_q.push_back(0);
        wb_q.push_back(0);
        if (m_op <= 6) wb_q.push_back(m_op == 1 ? 2 : 1);
        else if (m_op == 8)  pend_pc = (m_pc & ~15) | m_opr;
        else if (m_op == 15) pend_halt = 1;
        else if (m_op != 14) pend_ill = 1;
        m_phase = P_BUSY;
      end
      if (m_phase == P_BUSY) begin
        if (wb_q.size() > 0) begin
          v = wb_q.pop_front();
          e_rwe = (v == 1); e_mwe = (v == 2); e_busy = 1;
        end else begin
          m_pc = pend_pc;
          if (pend_ill) m_ill = 1;
          m_phase = pend_halt ? P_HALT : P_FETCH;
        end
      end
    end
  endtask

  // ---------------- memory responder and per-cycle compare ----------------
  logic [7:0] mem [0:255];
  int dly_fixed = 0;       // <0 selects a random wait per fetch
  int wait_left = 0;
  bit prev_req  = 0;
  int rwe_cnt = 0, mwe_cnt = 0, req_cnt = 0;

  task automatic cycle();
    bit a_rst, a_run, a_ack;
    int a_data;
    a_rst = rst; a_run = run; a_ack = imem_ack; a_data = int'(imem_data);
    @(posedge clk);
    #1;
    model_step(a_rst, a_run, a_ack, a_data);
    check("imem_req", int'(cur_req), int'(m_phase == P_FETCH));
    check("imem_addr", int'(cur_addr), m_pc);
    check("reg_we", int'(cur_rwe), int'(e_rwe));
    check("mem_we", int'(cur_mwe), int'(e_mwe));
    check("halted", int'(cur_halt), int'(m_phase == P_HALT));
    check("illegal", int'(cur_ill), int'(m_ill));
    if (e_busy) begin
      check("opcode", int'(cur_op), m_op);
      check("operand", int'(cur_opr), m_opr);
      check("alu_ctrl", int'(cur_alu), alu_of(m_op));
    end
    rwe_cnt += int'(cur_rwe);
    mwe_cnt += int'(cur_mwe);
    req_cnt += int'(cur_req);
    if (cur_req) begin
      if (!prev_req) wait_left = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 3));
      if (wait_left == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem[cur_addr];
      end else begin
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        wait_left--;
      end
    end else begin
      imem_ack  = ($urandom_range(0, 3) == 0);
      imem_data = 8'($urandom);
    end
    prev_req = cur_req;
  endtask

  task automatic wait_req(input int max_cycles);
    int i = 0;
    while (!cur_req && i < max_cycles) begin
      cycle();
      i++;
    end
    check("wait_req", int'(cur_req), 1);
  endtask

  int cap_op = 0, cap_opr = 0, cap_alu = 0;

  // Runs from the first FETCH cycle of one instruction to the first FETCH cycle of the next.
  task automatic run_instr(output int fc, output int tot, output bit moved);
    bit seen_low = 0, done = 0;
    logic [7:0] a0;
    fc = 1; tot = 0; moved = 0; a0 = cur_addr;
    rwe_cnt = 0; mwe_cnt = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      cycle();
      tot++;
      if (cur_req) begin
        if (seen_low) done = 1;
        else begin
          fc++;
          if (cur_addr != a0) moved = 1;
        end
      end else if (!seen_low) begin
        seen_low = 1;
        cap_op = int'(cur_op); cap_opr = int'(cur_opr); cap_alu = int'(cur_alu);
      end
    end
    check("instr_done", int'(done), 1);
  endtask

  int fc, tot;
  bit moved;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    mem[8'h00] = 8'h23;
    mem[8'h01] = 8'h15;
    mem[8'h27] = 8'h8A;
    mem[8'h2A] = 8'h9C;
    mem[8'h2B] = 8'hF0;

    rst = 1'b1; run = 1'b0;
    cycle(); cycle();
    check("rst_addr", int'(cur_addr), 0);
    check("rst_req", int'(cur_req), 0);
    check("rst_opcode", int'(cur_op), 0);
    check("rst_alu", int'(cur_alu), 0);
    check("rst_illegal", int'(cur_ill), 0);

    // ADD 0x23 at address 0, ack on first fetch cycle
    rst = 1'b0; run = 1'b1; dly_fixed = 0;
    wait_req(20);
    check("add_fetch_addr", int'(cur_addr), 0);
    dly_fixed = 3;
    run_instr(fc, tot, moved);
    check("add_cycles", tot, 4);
    check("add_operand", cap_opr, 3);
    check("add_alu", cap_alu, 0);
    check("add_reg_we_pulses", rwe_cnt, 1);
    check("add_next_addr", int'(cur_addr), 1);

    // STORE 0x15 with a 3-cycle ack delay
    run = 1'b0;
    dly_fixed = 0;
    run_instr(fc, tot, moved);
    check("st_req_cycles", fc, 4);
    check("st_addr_moved", int'(moved), 0);
    check("st_cycles", tot, 7);
    check("st_mem_we_pulses", mwe_cnt, 1);
    check("st_reg_we_pulses", rwe_cnt, 0);

    // NOPs up to 0x27, then JMP 0x8A
    for (int i = 0; i < 60 && cur_addr != 8'h27; i++) run_instr(fc, tot, moved);
    check("reach_27", int'(cur_addr), 8'h27);
    run_instr(fc, tot, moved);
    check("jmp_cycles", tot, 3);
    check("jmp_target", int'(cur_addr), 8'h2A);
    check("jmp_we_pulses", rwe_cnt + mwe_cnt, 0);

    // Undefined opcode then HALT
    run_instr(fc, tot, moved);
    check("ill_cycles", tot, 3);
    check("ill_flag", int'(cur_ill), 1);
    cycle(); cycle(); cycle();
    run = 1'b1; req_cnt = 0;
    for (int i = 0; i < 10; i++) cycle();
    check("halt_no_fetch", req_cnt, 0);
    check("halt_flag", int'(cur_halt), 1);
    check("halt_ill_sticky", int'(cur_ill), 1);

    // Reset leaves HALT; then reset in WB of LOAD 0x04
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_halt_clr", int'(cur_halt), 0);
    check("rst_ill_clr", int'(cur_ill), 0);
    mem[8'h00] = 8'h04;
    wait_req(20);
    cycle(); cycle(); cycle();
    check("ld_wb_reg_we", int'(cur_rwe), 1);
    rst = 1'b1; cycle();
    check("ld_rst_reg_we", int'(cur_rwe), 0);
    check("ld_rst_mem_we", int'(cur_mwe), 0);
    check("ld_rst_req", int'(cur_req), 0);
    check("ld_rst_addr", int'(cur_addr), 0);
    check("ld_rst_opcode", int'(cur_op), 0);
    check("ld_rst_operand", int'(cur_opr), 0);
    rst = 1'b0; run = 1'b0; cycle();
    check("ld_rst_idle", int'(cur_req), 0);

    // PC_WIDTH=4: sixteen NOPs wrap the fetch address
    sel = 1'b1; rst = 1'b1; cycle();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    rst = 1'b0; run = 1'b1;
    wait_req(20);
    for (int k = 1; k <= 16; k++) begin
      run_instr(fc, tot, moved);
      if (k == 15) check("w4_addr_15", int'(cur_addr), 15);
      if (k == 16) check("w4_addr_wrap", int'(cur_addr), 0);
    end

    // Randomized programs, ack delays, spurious acks, run and reset
    dly_fixed = -1;
    for (int blk = 0; blk < 6; blk++) begin
      int r, v;
      sel = blk[0];
      for (int i = 0; i < 256; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 55)      v = int'($urandom_range(0, 6));
        else if (r < 70) v = 14;
        else if (r < 82) v = 8;
        else if (r < 98) begin
          v = int'($urandom_range(0, 5));
          v = (v == 0) ? 7 : 8 + v;
        end else         v = 15;
        mem[i] = 8'((v << 4) | int'($urandom_range(0, 15)));
      end
      rst = 1'b1; cycle();
      rst = 1'b0;
      for (int c = 0; c < 2500; c++) begin
        run = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 149) == 0);
        cycle();
      end
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, instruction-memory address width; legal range 4..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port run  input  1  level; leaves IDLE when high.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  PC_WIDTH  fetch address (current PC).
REQ-007 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-008 SHALL have port imem_data  input  8  instruction: [7:4] opcode, [3:0] operand.
REQ-009 SHALL have port opcode  output  4  latched opcode to datapath.
REQ-010 SHALL have port operand  output  4  latched operand to datapath.
REQ-011 SHALL have port alu_ctrl  output  3  ALU select to datapath.
REQ-012 SHALL have port reg_we  output  1  register-file write-enable pulse.
REQ-013 SHALL have port mem_we  output  1  data-memory write-enable pulse.
REQ-014 SHALL have port halted  output  1  high while in HALT.
REQ-015 SHALL have port illegal  output  1  sticky: an undefined opcode was executed.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-017 IDLE -> FETCH when run=1; otherwise it SHALL stay in IDLE.
REQ-018 FETCH SHALL hold imem_req=1 and imem_addr=PC steady until imem_ack=1. It SHALL then latch imem_data into the instruction register, drop imem_req on the next cycle, and go to DECODE.
REQ-019 imem_req SHALL be 0 in every state except FETCH; imem_ack outside FETCH SHALL be ignored.
REQ-020 DECODE SHALL drive alu_ctrl from opcode and go to EXEC. Mapping: 0010 ADD=000, 0011 SUB=001, 0100 AND=010, 0101 OR=011, 0110 XOR=100; all other opcodes=000.
REQ-021 EXEC -> WB for LOAD 0000, STORE 0001 and ALU ops 0010..0110.
REQ-022 EXEC SHALL handle the remaining opcodes as follows:
- JMP 1000: PC <= {PC[PC_WIDTH-1:4], operand}, then FETCH.
- NOP 1110: go to FETCH.
- HALT 1111: go to HALT.
- Any other opcode: set illegal=1 and treat as NOP.
REQ-023 WB SHALL assert the write enables for exactly one cycle, then go to FETCH:
- LOAD and ALU ops: reg_we=1.
- STORE: mem_we=1.
REQ-024 reg_we and mem_we SHALL never be 1 in the same cycle, and SHALL be 0 in every state other than WB.
REQ-025 opcode and operand SHALL stay constant from DECODE through WB of the same instruction.
REQ-026 PC SHALL increment by 1 modulo 2^PC_WIDTH on the imem_ack cycle; max value wraps to 0.
REQ-027 JMP SHALL override the increment already applied.
REQ-028 Latency per instruction, with imem_ack on the first FETCH cycle:
- LOAD, STORE, ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
- JMP, NOP, illegal: 3 cycles.
- Each extra wait cycle on imem_ack adds 1 cycle.
REQ-029 HALT SHALL be absorbing: halted=1, no fetch, run ignored; only rst exits.
REQ-030 run=0 while running SHALL NOT stop execution; run is sampled only in IDLE.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL enter IDLE with: PC=0, instruction register=0, opcode=0, operand=0, alu_ctrl=000, imem_req=0, reg_we=0, mem_we=0, halted=0, illegal=0.
REQ-032 rst SHALL take priority over every transition, including mid-FETCH with imem_ack=1 and in WB. No write-enable pulse SHALL appear in the cycle after the reset edge.
REQ-033 imem_addr SHALL equal PC at all times; after reset it reads 0.

Verification
REQ-034 Bench SHALL cover: reset, then run=1, imem_ack tied 1, program 0x23 (ADD) at addr 0 -> FETCH/DECODE/EXEC/WB in 4 cycles; alu_ctrl=000, operand=3, one reg_we pulse in WB, imem_addr=1 at next FETCH.
REQ-035 Bench SHALL cover: STORE 0x15 with imem_ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable; one mem_we pulse; reg_we stays 0.
REQ-036 Bench SHALL cover: PC=0x27 fetching JMP 0x8A -> next fetch at 0x2A in 3 cycles; no write-enable pulses.
REQ-037 Bench SHALL cover: PC_WIDTH=4, sixteen NOPs (0xE0) -> imem_addr wraps from 15 to 0.
REQ-038 Bench SHALL cover: opcode 0x9X, then HALT 0xF0 -> illegal=1 and stays 1; halted=1; imem_req stays 0 for 10 cycles despite run=1.
REQ-039 Bench SHALL cover: rst asserted during WB of LOAD 0x04 -> reg_we=0 on the following cycle; all outputs at the REQ-031 values; state IDLE.
